// File: rtl/i2c_bmp180_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bmp180_target
// Brief    : I2C target emulating the BMP180 register map (ID, ctrl, calib,
//            measurement). Optional soft reset via BMP180_SOFTRESET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bmp180_target #(
   parameter logic [6:0] ADR     = 7'h77,
   parameter logic [7:0] CHIP_ID = 8'h55,
   parameter int         FILT    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scl,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [23:0] meas_data,
   input  logic        cal_we,
   input  logic [4:0]  cal_addr,
   input  logic [7:0]  cal_din,
   output logic [7:0]  ctrl_meas,
   output logic        ctrl_wr,
   output logic        busy,
   output logic [3:0]  state
);
   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] ADDR      = 4'd1;
   localparam logic [3:0] ADDR_ACK  = 4'd2;
   localparam logic [3:0] IGNORE    = 4'd3;
   localparam logic [3:0] WPTR      = 4'd4;
   localparam logic [3:0] WPTR_ACK  = 4'd5;
   localparam logic [3:0] WDATA     = 4'd6;
   localparam logic [3:0] WDATA_ACK = 4'd7;
   localparam logic [3:0] RDATA     = 4'd8;
   localparam logic [3:0] RACK      = 4'd9;

   logic [1:0] pin_w, lvl_w, prv_w;
   assign pin_w = {scl, sda_in};

   // Per line: 2-FF synchroniser, stability filter, previous filtered level
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_in
         logic       s1_q, s1_d, s2_q, s2_d, f_q, f_d, p_q, p_d;
         logic [3:0] c_q, c_d;
         always_comb begin
            s1_d = pin_w[gi];
            s2_d = s1_q;
            p_d  = f_q;
            f_d  = f_q;
            c_d  = 4'd0;
            if (s2_q != f_q) begin
               if (c_q == 4'(FILT - 1)) f_d = s2_q;
               else                     c_d = c_q + 4'd1;
            end
         end
         always_ff @(posedge clk) begin
            if (reset) begin
               s1_q <= 1'b1;
               s2_q <= 1'b1;
               f_q  <= 1'b1;
               p_q  <= 1'b1;
               c_q  <= 4'd0;
            end else begin
               s1_q <= s1_d;
               s2_q <= s2_d;
               f_q  <= f_d;
               p_q  <= p_d;
               c_q  <= c_d;
            end
         end
         assign lvl_w[gi] = f_q;
         assign prv_w[gi] = p_q;
      end
   endgenerate

   logic sda_f, scl_rise, scl_fall, start_det, stop_det;
   assign sda_f     = lvl_w[0];
   assign scl_rise  =  lvl_w[1] & ~prv_w[1];
   assign scl_fall  = ~lvl_w[1] &  prv_w[1];
   assign start_det =  lvl_w[1] &  prv_w[1] &  prv_w[0] & ~lvl_w[0];
   assign stop_det  =  lvl_w[1] &  prv_w[1] & ~prv_w[0] &  lvl_w[0];

   logic [3:0]  st_q, st_d, bit_q, bit_d;
   logic [7:0]  sh_q, sh_d, tx_q, tx_d, ptr_q, ptr_d, ctrl_q, ctrl_d;
   logic        oe_q, oe_d, rw_q, rw_d, ctrl_wr_q, ctrl_wr_d;
   logic [23:0] shadow_q, shadow_d;
   logic [7:0]  cal_q [22];
   logic [7:0]  cal_d [22];
`ifdef BMP180_SOFTRESET_EN
   logic        srst_q, srst_d;
`endif

   function automatic logic [7:0] rd(input logic [7:0] a);
      rd = 8'h00;
      if (a >= 8'hAA && a <= 8'hBF) rd = cal_q[5'(a - 8'hAA)];
      else begin
         case (a)
            8'hD0:   rd = CHIP_ID;
            8'hF4:   rd = ctrl_q;
            8'hF6:   rd = shadow_q[23:16];
            8'hF7:   rd = shadow_q[15:8];
            8'hF8:   rd = shadow_q[7:0];
            default: rd = 8'h00;
         endcase
      end
   endfunction

   always_comb begin
      st_d      = st_q;
      bit_d     = bit_q;
      sh_d      = sh_q;
      tx_d      = tx_q;
      ptr_d     = ptr_q;
      oe_d      = oe_q;
      rw_d      = rw_q;
      ctrl_d    = ctrl_q;
      ctrl_wr_d = 1'b0;
      shadow_d  = shadow_q;
      cal_d     = cal_q;
`ifdef BMP180_SOFTRESET_EN
      srst_d    = srst_q;
`endif
      if (cal_we && cal_addr <= 5'd21) cal_d[cal_addr] = cal_din;
      if (start_det) begin
         st_d  = ADDR;
         bit_d = 4'd0;
         oe_d  = 1'b0;
      end else if (stop_det) begin
         st_d = IDLE;
         oe_d = 1'b0;
`ifdef BMP180_SOFTRESET_EN
         if (srst_q) begin
            ctrl_d = 8'h00;
            ptr_d  = 8'h00;
         end
         srst_d = 1'b0;
`endif
      end else if (scl_rise) begin
         case (st_q)
            ADDR, WPTR, WDATA: begin
               sh_d  = {sh_q[6:0], sda_f};
               bit_d = bit_q + 4'd1;
            end
            RDATA: bit_d = bit_q + 4'd1;
            RACK:  if (sda_f) st_d = IGNORE;
                   else       bit_d = 4'd9;
            default: ;
         endcase
      end else if (scl_fall) begin
         case (st_q)
            ADDR: if (bit_q == 4'd8) begin
               if (sh_q[7:1] == ADR) begin
                  st_d     = ADDR_ACK;
                  oe_d     = 1'b1;
                  rw_d     = sh_q[0];
                  shadow_d = meas_data;
               end else begin
                  st_d = IGNORE;
               end
            end
            ADDR_ACK: begin
               bit_d = 4'd0;
               if (rw_q) begin
                  st_d = RDATA;
                  tx_d = rd(ptr_q);
                  oe_d = ~tx_d[7];
               end else begin
                  st_d = WPTR;
                  oe_d = 1'b0;
               end
            end
            WPTR: if (bit_q == 4'd8) begin
               st_d  = WPTR_ACK;
               oe_d  = 1'b1;
               ptr_d = sh_q;
            end
            WDATA: if (bit_q == 4'd8) begin
               st_d  = WDATA_ACK;
               oe_d  = 1'b1;
               ptr_d = ptr_q + 8'd1;
               if (ptr_q == 8'hF4) begin
                  ctrl_d    = sh_q;
                  ctrl_wr_d = 1'b1;
               end
`ifdef BMP180_SOFTRESET_EN
               if (ptr_q == 8'hE0 && sh_q == 8'hB6) srst_d = 1'b1;
`endif
            end
            WPTR_ACK, WDATA_ACK: begin
               st_d  = WDATA;
               oe_d  = 1'b0;
               bit_d = 4'd0;
            end
            RDATA: if (bit_q == 4'd8) begin
               st_d = RACK;
               oe_d = 1'b0;
            end else begin
               tx_d = {tx_q[6:0], 1'b0};
               oe_d = ~tx_d[7];
            end
            // Master ACKed on the preceding rise: advance and drive next byte
            RACK: if (bit_q == 4'd9) begin
               st_d  = RDATA;
               bit_d = 4'd0;
               ptr_d = ptr_q + 8'd1;
               tx_d  = rd(ptr_q + 8'd1);
               oe_d  = ~tx_d[7];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q      <= IDLE;
         bit_q     <= 4'd0;
         sh_q      <= 8'h00;
         tx_q      <= 8'h00;
         ptr_q     <= 8'h00;
         oe_q      <= 1'b0;
         rw_q      <= 1'b0;
         ctrl_q    <= 8'h00;
         ctrl_wr_q <= 1'b0;
         shadow_q  <= 24'h0;
         for (int i = 0; i < 22; i++) cal_q[i] <= 8'h00;
`ifdef BMP180_SOFTRESET_EN
         srst_q    <= 1'b0;
`endif
      end else begin
         st_q      <= st_d;
         bit_q     <= bit_d;
         sh_q      <= sh_d;
         tx_q      <= tx_d;
         ptr_q     <= ptr_d;
         oe_q      <= oe_d;
         rw_q      <= rw_d;
         ctrl_q    <= ctrl_d;
         ctrl_wr_q <= ctrl_wr_d;
         shadow_q  <= shadow_d;
         cal_q     <= cal_d;
`ifdef BMP180_SOFTRESET_EN
         srst_q    <= srst_d;
`endif
      end
   end

   assign sda_oe    = oe_q;
   assign ctrl_meas = ctrl_q;
   assign ctrl_wr   = ctrl_wr_q;
   assign busy      = (st_q != IDLE);
   assign state     = st_q;
endmodule
`default_nettype wire

// File: tb/tb_i2c_bmp180_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bmp180_target
// Brief    : Bit-banged I2C master against i2c_bmp180_target, register-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bmp180_target;
   localparam int         Q         = 8;
   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_IGNORE = 4'd3;

   logic        clk = 1'b0, reset = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
   logic        sda_in, sda_oe, cal_we = 1'b0, ctrl_wr, busy;
   logic [23:0] meas_data = 24'h0;
   logic [4:0]  cal_addr = 5'd0;
   logic [7:0]  cal_din = 8'h00, ctrl_meas;
   logic [3:0]  state;
   int          n_assert = 0, n_fail = 0, wr_pulses = 0, oe_cycles = 0;

   logic [7:0]  cal_m [22];
   logic [7:0]  ctrl_m, ptr_m;
   logic [23:0] shadow_m;

   always #5 clk = ~clk;
   assign sda_in = m_sda & ~sda_oe;

   i2c_bmp180_target dut (
      .clk(clk), .reset(reset), .scl(m_scl), .sda_in(sda_in), .sda_oe(sda_oe),
      .meas_data(meas_data), .cal_we(cal_we), .cal_addr(cal_addr), .cal_din(cal_din),
      .ctrl_meas(ctrl_meas), .ctrl_wr(ctrl_wr), .busy(busy), .state(state)
   );

   always @(negedge clk) begin
      if (ctrl_wr) wr_pulses++;
      if (sda_oe)  oe_cycles++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_rd(input logic [7:0] a);
      int k;
      k = int'(a) - 170;
      if (k >= 0 && k <= 21) return cal_m[k];
      case (a)
         8'hD0:   return 8'h55;
         8'hF4:   return ctrl_m;
         8'hF6:   return shadow_m[23:16];
         8'hF7:   return shadow_m[15:8];
         8'hF8:   return shadow_m[7:0];
         default: return 8'h00;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b0; tick(Q);
   endtask

   task automatic bus_stop();
      m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
   endtask

   task automatic bus_bit(input logic b, output logic r);
      m_sda = b; tick(Q); m_scl = 1'b1; tick(Q); r = sda_in; tick(Q); m_scl = 1'b0; tick(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
      bus_bit(1'b1, r);
      ack = ~r;
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] d);
      logic r;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         bus_bit(1'b1, r);
         d = {d[6:0], r};
      end
      bus_bit(~mack, r);
   endtask

   task automatic cal_wr(input logic [4:0] a, input logic [7:0] v);
      cal_we = 1'b1; cal_addr = a; cal_din = v;
      tick(1);
      cal_we = 1'b0;
      if (a <= 5'd21) cal_m[a] = v;
   endtask

   task automatic wr_reg(input logic [7:0] p, input logic [7:0] v);
      logic ack;
      int   w0;
      w0 = wr_pulses;
      bus_start();
      wr_byte(8'hEE, ack); check("wr_addr_ack", ack, 1);
      wr_byte(p, ack);     check("wr_ptr_ack", ack, 1);
      wr_byte(v, ack);     check("wr_data_ack", ack, 1);
      bus_stop(); tick(2);
      if (p == 8'hF4) ctrl_m = v;
`ifdef BMP180_SOFTRESET_EN
      if (p == 8'hE0 && v == 8'hB6) ctrl_m = 8'h00;
`endif
      check($sformatf("ctrl_meas_after_wr_%02h", p), ctrl_meas, ctrl_m);
      check("ctrl_wr_pulses", wr_pulses - w0, (p == 8'hF4) ? 1 : 0);
   endtask

   // Set pointer, repeated START, burst-read n bytes (NACK on last).
   // meas_data is scrambled after the first byte to prove the shadow is coherent.
   task automatic rd_burst(input logic [7:0] p, input int n);
      logic       ack;
      logic [7:0] d;
      bus_start();
      wr_byte(8'hEE, ack); check("rd_waddr_ack", ack, 1);
      wr_byte(p, ack);     check("rd_ptr_ack", ack, 1);
      bus_start();
      wr_byte(8'hEF, ack); check("rd_raddr_ack", ack, 1);
      shadow_m = meas_data;
      ptr_m    = p;
      for (int i = 0; i < n; i++) begin
         rd_byte(i != n - 1, d);
         if (i == 0) meas_data = 24'($urandom);
         check($sformatf("rd_data_%02h", ptr_m), d, model_rd(ptr_m));
         if (i != n - 1) ptr_m = ptr_m + 8'd1;
      end
      tick(Q); check("oe_after_nack", sda_oe, 0);
      bus_stop(); tick(2);
      check("busy_after_stop", busy, 0);
   endtask

   initial begin
      logic       ack, r;
      logic [7:0] d;
      int         o0;
      for (int i = 0; i < 22; i++) cal_m[i] = 8'h00;
      ctrl_m = 8'h00; ptr_m = 8'h00; shadow_m = 24'h0;

      tick(3); reset = 1'b0; tick(3);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_ctrl_meas", ctrl_meas, 8'h00);
      check("rst_ctrl_wr", ctrl_wr, 0);
      check("rst_busy", busy, 0);
      check("rst_state", state, ST_IDLE);

      // Chip ID read, single byte with NACK
      rd_burst(8'hD0, 1);

      // Foreign address: never ACKed, never drives SDA
      o0 = oe_cycles;
      bus_start();
      wr_byte(8'hA0, ack); check("foreign_nack", ack, 0);
      check("foreign_state", state, ST_IGNORE);
      check("foreign_busy", busy, 1);
      wr_byte(8'h12, ack); check("foreign_data_nack", ack, 0);
      check("foreign_state2", state, ST_IGNORE);
      bus_stop(); tick(2);
      check("foreign_oe_cycles", oe_cycles - o0, 0);
      check("foreign_idle", state, ST_IDLE);

      // Control register write
      wr_reg(8'hF4, 8'h2E);

      // Coherent measurement burst
      meas_data = 24'h5A3C81;
      rd_burst(8'hF6, 3);

      // Calibration fill, out-of-range index ignored, wrap past 0xFF
      for (int i = 0; i < 22; i++) cal_wr(5'(i), 8'(i + 1));
      cal_wr(5'd22, 8'hEE);
      cal_wr(5'd31, 8'hDD);
      rd_burst(8'hAA, 23);
      rd_burst(8'hFF, 3);

      // Soft-reset command (no effect on ctrl_meas unless the feature is built in)
      wr_reg(8'hF4, 8'h74);
      wr_reg(8'hE0, 8'hB6);

      // Randomised register traffic against the model
      for (int it = 0; it < 10; it++) begin
         case ($urandom_range(0, 2))
            0: wr_reg(($urandom_range(0, 1) == 0) ? 8'hF4 : 8'($urandom), 8'($urandom));
            1: cal_wr(5'($urandom), 8'($urandom));
            default: begin
               case ($urandom_range(0, 4))
                  0: d = 8'hAA + 8'($urandom_range(0, 21));
                  1: d = 8'hD0;
                  2: d = 8'hF4;
                  3: d = 8'hF6;
                  default: d = 8'($urandom);
               endcase
               meas_data = 24'($urandom);
               rd_burst(d, $urandom_range(1, 4));
            end
         endcase
      end

      // Reset while the target drives a low data bit
      wr_reg(8'hF4, 8'h2E);
      bus_start();
      wr_byte(8'hEE, ack); check("mid_waddr_ack", ack, 1);
      wr_byte(8'hF4, ack); check("mid_ptr_ack", ack, 1);
      bus_start();
      wr_byte(8'hEF, ack); check("mid_raddr_ack", ack, 1);
      bus_bit(1'b1, r);    check("mid_bit7", r, 0);
      check("mid_bit6_driven", sda_oe, 1);
      reset = 1'b1;
      tick(1);
      check("mid_reset_release", sda_oe, 0);
      reset = 1'b0;
      for (int i = 0; i < 22; i++) cal_m[i] = 8'h00;
      ctrl_m = 8'h00; ptr_m = 8'h00;
      tick(2);
      check("mid_reset_ctrl", ctrl_meas, 8'h00);
      check("mid_reset_state", state, ST_IDLE);
      m_sda = 1'b1; tick(Q);
      bus_start();
      wr_byte(8'hEF, ack); check("post_rst_raddr_ack", ack, 1);
      rd_byte(1'b0, d);    check("post_rst_data", d, model_rd(ptr_m));
      tick(Q);             check("post_rst_oe", sda_oe, 0);
      bus_stop(); tick(2);
      check("post_rst_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
